// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI read-channel encodings, field widths and FSM states
package axi_pkg;

    localparam int ALEN_W   = 8;
    localparam int ASIZE_W  = 3;
    localparam int ABURST_W = 2;
    localparam int ACERR_W  = 2;

    localparam logic [ABURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [ABURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [ABURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [ACERR_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [ACERR_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [ACERR_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_RESP
`ifdef AXI_RD_DELAY_EN
        , ST_DELAY
`endif
    } state_t;

    function automatic logic wrap_len_ok(input logic [ALEN_W-1:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ASIZE_W-1:0]    size,
    input  logic [ALEN_W-1:0]     len,
    input  logic [ABURST_W-1:0]   burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] bnd_mask;

    always_comb begin
        incr     = ADDR_WIDTH'(1) << size;
        aligned  = addr & ~(incr - ADDR_WIDTH'(1));
        bnd_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = aligned + incr;
            // stay inside the wrap window: keep the window base, roll the offset
            BURST_WRAP:  next_addr = (addr & ~bnd_mask) | ((addr + incr) & bnd_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_inst_rd_slave.sv
// rtl/axi_inst_rd_slave.sv - AXI4 read responder over a sync-read SRAM
// Optional random per-beat wait injection: define AXI_RD_DELAY_EN.
module axi_inst_rd_slave
    import axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] MEM_BYTES  = 32'h0800_0000
`ifdef AXI_RD_DELAY_EN
    , parameter int                  MAX_DELAY  = 7
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [DATA_WIDTH-1:0] araddr,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ALEN_W-1:0]     arlen,
    input  logic [ASIZE_W-1:0]    arsize,
    input  logic [ABURST_W-1:0]   arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ACERR_W-1:0]    rresp,
    output logic                  rlast,
    output logic [ID_WIDTH-1:0]   rid,
    output logic                  mem_en,
    output logic [DATA_WIDTH-3:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state;
    logic [DATA_WIDTH-1:0] addr_q, next_addr, issue_addr, rdata_q;
    logic [ALEN_W-1:0]     len_q, cnt_q;
    logic [ASIZE_W-1:0]    size_q;
    logic [ABURST_W-1:0]   burst_q;
    logic [ACERR_W-1:0]    beat_resp_q, issue_resp;
    logic                  slverr_q, beat_ok_q, fresh_q;
    logic                  accept, last_beat, start, ar_slverr, issue_slverr, issue_ok;
    logic [1:0]            ar_misalign;

    axi_burst_addr_gen #(.ADDR_WIDTH(DATA_WIDTH)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    assign accept    = (state == ST_IDLE) && arvalid && arready;
    assign last_beat = (cnt_q == len_q);
    assign start     = accept || ((state == ST_RESP) && rready && !last_beat);
    // SRAM output is live only on the first RESP cycle; after that the captured copy holds it
    assign rdata     = fresh_q ? mem_rdata : rdata_q;

    always_comb begin
        case (arsize)
            3'd1:    ar_misalign = {1'b0, araddr[0]};
            3'd2:    ar_misalign = araddr[1:0];
            default: ar_misalign = 2'b00;
        endcase
        ar_slverr = (arsize > 3'd2) ||
                    ((arburst == BURST_WRAP) && (!wrap_len_ok(arlen) || (ar_misalign != 2'b00)));
        issue_addr   = (state == ST_IDLE) ? araddr : next_addr;
        issue_slverr = (state == ST_IDLE) ? ar_slverr : slverr_q;
        issue_resp   = RESP_OKAY;
        if (issue_slverr)
            issue_resp = RESP_SLVERR;
        else if ((issue_addr - MEM_BASE) >= MEM_BYTES)
            issue_resp = RESP_DECERR;
        issue_ok = (issue_resp == RESP_OKAY);
    end

`ifdef AXI_RD_DELAY_EN
    logic [7:0] lfsr_q, dly_cnt_q, dly;
    assign dly = 8'(32'(lfsr_q) % (MAX_DELAY + 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            arready     <= 1'b0;
            rvalid      <= 1'b0;
            rresp       <= '0;
            rlast       <= 1'b0;
            rid         <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_resp_q <= '0;
            slverr_q    <= 1'b0;
            beat_ok_q   <= 1'b0;
            fresh_q     <= 1'b0;
`ifdef AXI_RD_DELAY_EN
            lfsr_q      <= 8'hA5;
            dly_cnt_q   <= '0;
`endif
        end else begin
            mem_en <= 1'b0;
`ifdef AXI_RD_DELAY_EN
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            case (state)
                ST_IDLE: begin
                    arready <= 1'b1;
                    if (accept) begin
                        arready  <= 1'b0;
                        rid      <= arid;
                        len_q    <= arlen;
                        size_q   <= arsize;
                        burst_q  <= arburst;
                        slverr_q <= ar_slverr;
                    end
                end
                ST_RD: begin
                    rvalid  <= 1'b1;
                    rresp   <= beat_resp_q;
                    rlast   <= last_beat;
                    fresh_q <= beat_ok_q;
                    rdata_q <= '0;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (fresh_q) begin
                        rdata_q <= mem_rdata;
                        fresh_q <= 1'b0;
                    end
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (last_beat) begin
                            state   <= ST_IDLE;
                            arready <= 1'b1;
                        end
                    end
                end
`ifdef AXI_RD_DELAY_EN
                ST_DELAY: begin
                    if (dly_cnt_q == 8'd0) begin
                        mem_en <= beat_ok_q;
                        state  <= ST_RD;
                    end else begin
                        dly_cnt_q <= dly_cnt_q - 8'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase

            // launch a beat: new burst from IDLE or the next beat after a completed handshake
            if (start) begin
                addr_q      <= issue_addr;
                cnt_q       <= accept ? '0 : cnt_q + 8'd1;
                mem_addr    <= issue_addr[DATA_WIDTH-1:2];
                beat_resp_q <= issue_resp;
                beat_ok_q   <= issue_ok;
`ifdef AXI_RD_DELAY_EN
                if (dly != 8'd0) begin
                    state     <= ST_DELAY;
                    dly_cnt_q <= dly - 8'd1;
                end else begin
                    mem_en <= issue_ok;
                    state  <= ST_RD;
                end
`else
                mem_en <= issue_ok;
                state  <= ST_RD;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axi_inst_rd_slave.sv
// tb/tb_axi_inst_rd_slave.sv - directed self-checking bench for axi_inst_rd_slave
module tb_axi_inst_rd_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          en_cnt = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    axi_inst_rd_slave dut (
        .clk       (clk),
        .rst       (rst),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arid      (arid),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rid       (rid),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[5:0]];
            en_cnt    <= en_cnt + 1;
        end
    end

    function automatic logic [31:0] memval(input int i);
        return 32'hD000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] b);
        int n;
        n = 0;
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = b; arvalid = 1'b1;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!arready) $display("FAIL ar_handshake_timeout addr %h arready %b required 1", a, arready);
        else n_pass++;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output logic to);
        int n;
        n = 0;
        while (!rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        to = !rvalid;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_total++;
        if ({arready, rvalid, rlast, mem_en} !== 4'b0000)
            $display("FAIL reset_ctrl got %b required 0000", {arready, rvalid, rlast, mem_en});
        else n_pass++;
        n_total++;
        if ({rdata, rresp, rid} !== 38'd0)
            $display("FAIL reset_data got %h/%b/%h required 0", rdata, rresp, rid);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (arready !== 1'b1) $display("FAIL reset_arready got %b required 1", arready);
        else n_pass++;
    endtask

    task automatic test_single;
        send_ar(32'h8000_0000, 4'd3, 8'd0, 3'd2, 2'b01);
        n_total++;
        if ({mem_en, mem_addr, rvalid} !== {1'b1, 30'h2000_0000, 1'b0})
            $display("FAIL single_mem_en got en %b addr %h rvalid %b required 1 20000000 0", mem_en, mem_addr, rvalid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, memval(0), 2'b00, 1'b1, 4'd3})
            $display("FAIL single_beat got v%b %h r%b l%b id%h required v1 %h r00 l1 id3", rvalid, rdata, rresp, rlast, rid, memval(0));
        else n_pass++;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        n_total++;
        if ({rvalid, arready} !== 2'b01)
            $display("FAIL single_done got rvalid %b arready %b required 0 1", rvalid, arready);
        else n_pass++;
    endtask

    task automatic test_incr_stall;
        logic to;
        int   c0;
        c0 = en_cnt;
        send_ar(32'h8000_0010, 4'd5, 8'd3, 3'd2, 2'b01);
        for (int b = 0; b < 4; b++) begin
            wait_rvalid(to);
            n_total++;
            if (to) $display("FAIL incr_timeout beat %0d rvalid 0 required 1", b);
            else n_pass++;
            n_total++;
            if ({rdata, rresp, rlast, rid} !== {memval(4 + b), 2'b00, (b == 3), 4'd5})
                $display("FAIL incr_beat%0d got %h r%b l%b id%h required %h r00 l%0d id5", b, rdata, rresp, rlast, rid, memval(4 + b), (b == 3));
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({rvalid, rdata, rlast} !== {1'b1, memval(4 + b), (b == 3)})
                $display("FAIL incr_hold%0d got v%b %h l%b required v1 %h", b, rvalid, rdata, rlast, memval(4 + b));
            else n_pass++;
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        n_total++;
        if (en_cnt - c0 !== 4) $display("FAIL incr_mem_en_count got %0d required 4", en_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_wrap;
        logic to;
        int   widx [4];
        widx = '{14, 15, 12, 13};
        send_ar(32'h8000_0038, 4'd6, 8'd3, 3'd2, 2'b10);
        rready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_rvalid(to);
            n_total++;
            if (to || {rdata, rresp, rlast} !== {memval(widx[b]), 2'b00, (b == 3)})
                $display("FAIL wrap_beat%0d got %h r%b l%b to%b required %h r00 l%0d", b, rdata, rresp, rlast, to, memval(widx[b]), (b == 3));
            else n_pass++;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic test_errors;
        logic        to;
        int          c0;
        logic [1:0]  er;
        logic [31:0] ed;
        logic [31:0] e_addr [4];
        logic [7:0]  e_len  [4];
        logic [2:0]  e_size [4];
        logic [1:0]  e_bur  [4];
        e_addr = '{32'h0000_1000, 32'h8000_0000, 32'h8000_0000, 32'h87FF_FFFC};
        e_len  = '{8'd1, 8'd0, 8'd2, 8'd1};
        e_size = '{3'd2, 3'd3, 3'd2, 3'd2};
        e_bur  = '{2'b01, 2'b01, 2'b10, 2'b01};
        c0 = en_cnt;
        rready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t == 3) begin
                n_total++;
                if (en_cnt - c0 !== 0) $display("FAIL err_mem_en got %0d strobes required 0", en_cnt - c0);
                else n_pass++;
            end
            send_ar(e_addr[t], 4'(7 + t), e_len[t], e_size[t], e_bur[t]);
            for (int b = 0; b <= int'(e_len[t]); b++) begin
                er = (t == 3 && b == 0) ? 2'b00 : (t == 0 || t == 3) ? 2'b11 : 2'b10;
                ed = (t == 3 && b == 0) ? memval(63) : 32'd0;
                wait_rvalid(to);
                n_total++;
                if (to || {rdata, rresp, rlast, rid} !== {ed, er, (b == int'(e_len[t])), 4'(7 + t)})
                    $display("FAIL err%0d_beat%0d got %h r%b l%b id%h to%b required %h r%b", t, b, rdata, rresp, rlast, rid, to, ed, er);
                else n_pass++;
                @(negedge clk);
            end
        end
        rready = 1'b0;
        n_total++;
        if (en_cnt - c0 !== 1) $display("FAIL err_boundary_mem_en got %0d required 1", en_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic busy_ok;
        logic found;
        int   n;
        send_ar(32'h8000_0000, 4'd1, 8'd1, 3'd2, 2'b01);
        araddr = 32'h8000_0020; arid = 4'd2; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        rready  = 1'b1;
        busy_ok = 1'b1;
        found   = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            if (arready) busy_ok = 1'b0;
            if (rvalid && rlast) found = 1'b1;
            else @(negedge clk);
            n++;
        end
        n_total++;
        if (!(found && busy_ok)) $display("FAIL b2b_busy got found %b busy_ok %b required 1 1", found, busy_ok);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (arready !== 1'b1) $display("FAIL b2b_arready got %b required 1", arready);
        else n_pass++;
        @(negedge clk);
        arvalid = 1'b0;
        n_total++;
        if ({arready, mem_en, mem_addr} !== {1'b0, 1'b1, 30'h2000_0008})
            $display("FAIL b2b_accept got rdy %b en %b addr %h required 0 1 20000008", arready, mem_en, mem_addr);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({rvalid, rid, rdata, rlast} !== {1'b1, 4'd2, memval(8), 1'b1})
            $display("FAIL b2b_beat got v%b id%h %h l%b required v1 id2 %h l1", rvalid, rid, rdata, rlast, memval(8));
        else n_pass++;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic to;
        logic quiet;
        int   beats;
        send_ar(32'h8000_0000, 4'd4, 8'd7, 3'd2, 2'b01);
        rready = 1'b1;
        beats  = 0;
        to     = 1'b0;
        while (beats < 2 && !to) begin
            wait_rvalid(to);
            if (!to) beats++;
            if (beats < 2 && !to) @(negedge clk);
        end
        n_total++;
        if (beats !== 2) $display("FAIL rstmid_reach got %0d beats required 2", beats);
        else n_pass++;
        rst = 1'b1;
        rready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rvalid, arready, mem_en} !== 3'b000)
            $display("FAIL rstmid_abort got v%b rdy%b en%b required 000", rvalid, arready, mem_en);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({arready, rvalid} !== 2'b10) $display("FAIL rstmid_arready got rdy%b v%b required 1 0", arready, rvalid);
        else n_pass++;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rvalid) quiet = 1'b0;
        end
        n_total++;
        if (!quiet) $display("FAIL rstmid_dropped got rvalid 1 required 0");
        else n_pass++;
        send_ar(32'h8000_0004, 4'hA, 8'd0, 3'd2, 2'b01);
        @(negedge clk);
        n_total++;
        if ({rvalid, rid, rdata, rlast} !== {1'b1, 4'hA, memval(1), 1'b1})
            $display("FAIL rstmid_recover got v%b id%h %h l%b required v1 idA %h l1", rvalid, rid, rdata, rlast, memval(1));
        else n_pass++;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = memval(i);
        test_reset;
        test_single;
        test_incr_stall;
        test_wrap;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
